// File: rtl/iq_alloc_ctrl_pkg.sv
// rtl/iq_alloc_ctrl_pkg.sv - shared sizes, types and helpers for the issue-queue allocator
//
// Purpose : issue-queue geometry, the almost-full threshold, vector/index/count
//           types and the one-hot / popcount helpers used by the allocator.
// Ports   : none (package)
package iq_alloc_ctrl_pkg;

  localparam int IQ_ENT_NUM   = 16;
  localparam int IQ_ENT_SEL   = 4;
  localparam int IQ_AFULL_THR = 4;

  typedef logic [IQ_ENT_NUM-1:0] iq_vec_t;
  typedef logic [IQ_ENT_SEL-1:0] iq_idx_t;
  typedef logic [IQ_ENT_SEL:0]   iq_cnt_t;

  function automatic iq_vec_t idx_onehot(input iq_idx_t idx);
    iq_vec_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic iq_cnt_t popcnt(input iq_vec_t v);
    iq_cnt_t c;
    c = '0;
    for (int i = 0; i < IQ_ENT_NUM; i++) begin
      c = c + iq_cnt_t'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/iq_alloc_ctrl_pick_first2.sv
// rtl/iq_alloc_ctrl_pick_first2.sv - picks the two lowest set bits of a free vector
//
// Purpose : priority encoder returning the lowest and next-lowest free entry.
// Ports   : i_free  free-entry vector (bit set = entry free)
//           o_v1    a first free entry exists
//           o_idx1  lowest free entry
//           o_v2    a second free entry exists
//           o_idx2  next-lowest free entry
module iq_alloc_ctrl_pick_first2
  import iq_alloc_ctrl_pkg::*;
(
  input  logic [IQ_ENT_NUM-1:0] i_free,
  output logic                  o_v1,
  output logic [IQ_ENT_SEL-1:0] o_idx1,
  output logic                  o_v2,
  output logic [IQ_ENT_SEL-1:0] o_idx2
);

  logic [IQ_ENT_NUM-1:0] w_free2;

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    o_v1   = 1'b0;
    o_idx1 = '0;
    for (int i = IQ_ENT_NUM - 1; i >= 0; i--) begin
      if (i_free[i]) begin
        o_v1   = 1'b1;
        o_idx1 = IQ_ENT_SEL'(i);
      end
    end
  end

  // Second pick sees the same vector with the first winner removed.
  always_comb begin
    w_free2 = i_free & ~(o_v1 ? idx_onehot(o_idx1) : '0);
    o_v2    = 1'b0;
    o_idx2  = '0;
    for (int i = IQ_ENT_NUM - 1; i >= 0; i--) begin
      if (w_free2[i]) begin
        o_v2   = 1'b1;
        o_idx2 = IQ_ENT_SEL'(i);
      end
    end
  end

endmodule

// File: rtl/iq_alloc_ctrl.sv
// rtl/iq_alloc_ctrl.sv - issue-queue slot allocator between dispatch and the issue queue
//
// Purpose : tracks busy IQ entries, hands dispatch up to two free entries per
//           cycle, reclaims entries granted by the three select ports and
//           bulk-frees wrong-path entries on a branch mispredict.
// Ports   : i_clk, i_reset_n            clock, async active-low reset
//           i_req_1, i_req_2            dispatch slot 1/2 holds an instruction
//           i_ext_stall                 stall from other dispatch resources
//           i_grant_k, i_sel_ent_k      select port k issued entry sel_ent_k (k=1..3)
//           i_prmiss, i_flush_mask      mispredict recovery and wrong-path entries
//           o_iq_entry_num_1/2          entries offered to dispatch slot 1/2
//           o_invalid1/2                slot not written into the IQ this cycle
//           o_iq_stall                  not enough free entries for the request
//           o_free_cnt                  registered number of free entries
//           o_almost_full               registered free_cnt <= threshold
//           o_err_dbl_free              sticky: grant of an already-free entry
module iq_alloc_ctrl
  import iq_alloc_ctrl_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_req_1,
  input  logic                  i_req_2,
  input  logic                  i_ext_stall,
  input  logic                  i_grant_1,
  input  logic                  i_grant_2,
  input  logic                  i_grant_3,
  input  logic [IQ_ENT_SEL-1:0] i_sel_ent_1,
  input  logic [IQ_ENT_SEL-1:0] i_sel_ent_2,
  input  logic [IQ_ENT_SEL-1:0] i_sel_ent_3,
  input  logic                  i_prmiss,
  input  logic [IQ_ENT_NUM-1:0] i_flush_mask,
  output logic [IQ_ENT_SEL-1:0] o_iq_entry_num_1,
  output logic [IQ_ENT_SEL-1:0] o_iq_entry_num_2,
  output logic                  o_invalid1,
  output logic                  o_invalid2,
  output logic                  o_iq_stall,
  output logic [IQ_ENT_SEL:0]   o_free_cnt,
  output logic                  o_almost_full,
  output logic                  o_err_dbl_free
);

  iq_vec_t r_busy;
  iq_cnt_t r_free_cnt;
  logic    r_almost_full;
  logic    r_err_dbl_free;

  logic    w_v1;
  logic    w_v2;
  iq_idx_t w_idx1;
  iq_idx_t w_idx2;
  logic    w_compact;
  iq_idx_t w_ent_2;
  logic    w_ent_2_v;
  iq_cnt_t w_need;
  logic    w_stall;
  logic    w_fire;
  logic    w_alloc_1;
  logic    w_alloc_2;
  iq_vec_t w_alloc_mask;
  iq_vec_t w_grant_mask;
  iq_vec_t w_rel_mask;
  logic    w_dbl_free;
  iq_vec_t w_flush_mask;
  iq_vec_t w_busy_nxt;
  iq_cnt_t w_free_cnt_nxt;

  // Only entries free at the start of the cycle are candidates, so an entry
  // released this cycle can never be re-allocated before the next edge.
  iq_alloc_ctrl_pick_first2 u_pick (
    .i_free (~r_busy),
    .o_v1   (w_v1),
    .o_idx1 (w_idx1),
    .o_v2   (w_v2),
    .o_idx2 (w_idx2)
  );

  // A lone request in slot 2 takes the lowest free entry.
  assign w_compact = ~i_req_1 & i_req_2;
  assign w_ent_2   = w_compact ? w_idx1 : w_idx2;
  assign w_ent_2_v = w_compact ? w_v1 : w_v2;

  // All-or-nothing: a pair never dispatches just one half.
  assign w_need  = iq_cnt_t'(i_req_1) + iq_cnt_t'(i_req_2);
  assign w_stall = w_need > r_free_cnt;
  assign w_fire  = ~w_stall & ~i_ext_stall & ~i_prmiss;

  assign w_alloc_1    = i_req_1 & w_fire & w_v1;
  assign w_alloc_2    = i_req_2 & w_fire & w_ent_2_v;
  assign w_alloc_mask = (w_alloc_1 ? idx_onehot(w_idx1) : '0)
                      | (w_alloc_2 ? idx_onehot(w_ent_2) : '0);

  // OR of the one-hot grants collapses duplicate ports onto one entry.
  assign w_grant_mask = (i_grant_1 ? idx_onehot(i_sel_ent_1) : '0)
                      | (i_grant_2 ? idx_onehot(i_sel_ent_2) : '0)
                      | (i_grant_3 ? idx_onehot(i_sel_ent_3) : '0);
  assign w_rel_mask   = w_grant_mask & r_busy;
  assign w_dbl_free   = |(w_grant_mask & ~r_busy);

  // Flush counts only entries that were busy and not already released, so
  // nothing is credited back twice.
  assign w_flush_mask = i_prmiss ? (i_flush_mask & r_busy & ~w_rel_mask) : '0;

  assign w_busy_nxt     = (r_busy & ~w_rel_mask & ~w_flush_mask) | w_alloc_mask;
  assign w_free_cnt_nxt = r_free_cnt + popcnt(w_rel_mask) + popcnt(w_flush_mask)
                        - popcnt(w_alloc_mask);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_busy         <= '0;
      r_free_cnt     <= iq_cnt_t'(IQ_ENT_NUM);
      r_almost_full  <= 1'b0;
      r_err_dbl_free <= 1'b0;
    end else begin
      r_busy         <= w_busy_nxt;
      r_free_cnt     <= w_free_cnt_nxt;
      r_almost_full  <= (w_free_cnt_nxt <= iq_cnt_t'(IQ_AFULL_THR));
      r_err_dbl_free <= r_err_dbl_free | w_dbl_free;
    end
  end

  assign o_iq_entry_num_1 = w_idx1;
  assign o_iq_entry_num_2 = w_ent_2;
  assign o_invalid1       = ~w_alloc_1;
  assign o_invalid2       = ~w_alloc_2;
  assign o_iq_stall       = w_stall;
  assign o_free_cnt       = r_free_cnt;
  assign o_almost_full    = r_almost_full;
  assign o_err_dbl_free   = r_err_dbl_free;

endmodule

// File: tb/tb_iq_alloc_ctrl.sv
// tb/tb_iq_alloc_ctrl.sv - scoreboard bench for the issue-queue allocator
module tb_iq_alloc_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_1, req_2, ext_stall;
  logic        grant_1, grant_2, grant_3;
  logic [3:0]  sel_ent_1, sel_ent_2, sel_ent_3;
  logic        prmiss;
  logic [15:0] flush_mask;
  logic [3:0]  num_1, num_2;
  logic        invalid1, invalid2, iq_stall;
  logic [4:0]  free_cnt;
  logic        almost_full, err_dbl_free;

  always #5 clk = ~clk;

  iq_alloc_ctrl dut (
    .i_clk            (clk),
    .i_reset_n        (reset_n),
    .i_req_1          (req_1),
    .i_req_2          (req_2),
    .i_ext_stall      (ext_stall),
    .i_grant_1        (grant_1),
    .i_grant_2        (grant_2),
    .i_grant_3        (grant_3),
    .i_sel_ent_1      (sel_ent_1),
    .i_sel_ent_2      (sel_ent_2),
    .i_sel_ent_3      (sel_ent_3),
    .i_prmiss         (prmiss),
    .i_flush_mask     (flush_mask),
    .o_iq_entry_num_1 (num_1),
    .o_iq_entry_num_2 (num_2),
    .o_invalid1       (invalid1),
    .o_invalid2       (invalid2),
    .o_iq_stall       (iq_stall),
    .o_free_cnt       (free_cnt),
    .o_almost_full    (almost_full),
    .o_err_dbl_free   (err_dbl_free)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic [15:0] mb;
  logic        merr;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL sb_empty observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    push(tag, exp);
    pop_check(obs);
  endtask

  function automatic int lowest_free(input logic [15:0] b, input int skip);
    for (int i = 0; i < 16; i++) begin
      if (!b[i] && i != skip) return i;
    end
    return -1;
  endfunction

  task automatic idle_inputs();
    req_1 = 0; req_2 = 0; ext_stall = 0;
    grant_1 = 0; grant_2 = 0; grant_3 = 0;
    sel_ent_1 = 0; sel_ent_2 = 0; sel_ent_3 = 0;
    prmiss = 0; flush_mask = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    mb   = '0;
    merr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus; the model predicts outputs from the current
  // state, then advances itself for the edge.
  task automatic step(input logic r1, input logic r2, input logic ext,
                      input logic g1, input logic [3:0] s1,
                      input logic g2, input logic [3:0] s2,
                      input logic g3, input logic [3:0] s3,
                      input logic pm, input logic [15:0] fm, input string tag);
    int          nfree, e1, e2, ent1, ent2, need;
    logic        stall, fire, chk1, chk2;
    logic [15:0] rel, fl, al;
    req_1 = r1; req_2 = r2; ext_stall = ext;
    grant_1 = g1; sel_ent_1 = s1; grant_2 = g2; sel_ent_2 = s2;
    grant_3 = g3; sel_ent_3 = s3; prmiss = pm; flush_mask = fm;

    nfree = 16 - $countones(mb);
    e1    = lowest_free(mb, -1);
    e2    = lowest_free(mb, e1);
    need  = int'(r1) + int'(r2);
    stall = need > nfree;
    fire  = !stall && !ext && !pm;
    ent1  = e1;
    ent2  = (!r1 && r2) ? e1 : e2;
    chk1  = nfree >= 1;
    chk2  = (nfree >= 2) || (!r1 && r2 && nfree >= 1);

    push({tag, "_free_cnt"}, 32'(nfree));
    push({tag, "_afull"}, 32'(nfree <= 4));
    push({tag, "_err"}, 32'(merr));
    push({tag, "_stall"}, 32'(stall));
    push({tag, "_inv1"}, 32'(!(r1 && fire)));
    push({tag, "_inv2"}, 32'(!(r2 && fire)));
    if (chk1) push({tag, "_num1"}, 32'(ent1));
    if (chk2) push({tag, "_num2"}, 32'(ent2));

    @(negedge clk);
    pop_check(32'(free_cnt));
    pop_check(32'(almost_full));
    pop_check(32'(err_dbl_free));
    pop_check(32'(iq_stall));
    pop_check(32'(invalid1));
    pop_check(32'(invalid2));
    if (chk1) pop_check(32'(num_1));
    if (chk2) pop_check(32'(num_2));

    rel = '0;
    if (g1) begin if (mb[s1]) rel[s1] = 1'b1; else merr = 1'b1; end
    if (g2) begin if (mb[s2]) rel[s2] = 1'b1; else merr = 1'b1; end
    if (g3) begin if (mb[s3]) rel[s3] = 1'b1; else merr = 1'b1; end
    al = '0;
    if (fire) begin
      if (r1) al[ent1] = 1'b1;
      if (r2) al[ent2] = 1'b1;
    end
    fl = pm ? (fm & mb & ~rel) : '0;
    mb = (mb & ~rel & ~fl) | al;

    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic pair(input string tag);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, tag);
  endtask

  task automatic idle(input string tag);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, tag);
  endtask

  initial begin
    idle_inputs();
    do_reset();

    check("rst_free_cnt", 32'(free_cnt), 16);
    check("rst_num1", 32'(num_1), 0);
    check("rst_num2", 32'(num_2), 1);
    check("rst_stall", 32'(iq_stall), 0);
    idle("rst");

    // fill with eight pairs
    for (int k = 0; k < 8; k++) begin
      check("t1_pair_num1", 32'(num_1), 32'(2 * k));
      check("t1_pair_num2", 32'(num_2), 32'(2 * k + 1));
      pair("t1_fill");
    end
    check("t1_full_cnt", 32'(free_cnt), 0);
    pair("t1_full_req");

    // release 5 on a full queue, then pair stalls and single gets 5
    step(0, 0, 0, 1, 4'd5, 0, 0, 0, 0, 0, 16'h0, "t2_grant5");
    check("t2_cnt1", 32'(free_cnt), 1);
    pair("t2_pair_stall");
    check("t2_single_num", 32'(num_1), 5);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, "t2_single");
    check("t2_cnt0", 32'(free_cnt), 0);

    // free 0 and 1, then allocate them while 7 and 9 are released
    step(0, 0, 0, 1, 4'd0, 1, 4'd1, 0, 0, 0, 16'h0, "t3_free01");
    step(1, 1, 0, 0, 0, 1, 4'd7, 1, 4'd9, 0, 16'h0, "t3_mix");
    check("t3_busy0", 32'(dut.r_busy[0]), 1);
    check("t3_busy1", 32'(dut.r_busy[1]), 1);
    check("t3_busy7", 32'(dut.r_busy[7]), 0);
    check("t3_busy9", 32'(dut.r_busy[9]), 0);
    check("t3_cnt", 32'(free_cnt), 2);
    idle("t3_after");

    // mispredict with 10 busy
    do_reset();
    for (int k = 0; k < 5; k++) pair("t4_fill");
    check("t4_cnt6", 32'(free_cnt), 6);
    step(1, 1, 0, 1, 4'd3, 0, 0, 0, 0, 1, 16'hFF00, "t4_prmiss");
    check("t4_cnt9", 32'(free_cnt), 9);
    check("t4_busy", 32'(dut.r_busy), 32'h00F7);

    // double free is sticky and ignored; duplicate grant counts once
    step(0, 0, 0, 1, 4'd12, 0, 0, 0, 0, 0, 16'h0, "t5_dbl");
    check("t5_err", 32'(err_dbl_free), 1);
    check("t5_cnt", 32'(free_cnt), 9);
    step(0, 0, 0, 1, 4'd4, 1, 4'd4, 0, 0, 0, 16'h0, "t5_dup");
    check("t5_dup_cnt", 32'(free_cnt), 10);
    check("t5_err_sticky", 32'(err_dbl_free), 1);
    idle("t5_after");

    // asynchronous reset mid-fill, then almost_full at 5 -> 4
    for (int k = 0; k < 3; k++) pair("t6_pre");
    check("t6_cnt_pre", 32'(free_cnt), 4);
    do_reset();
    for (int k = 0; k < 5; k++) pair("t6_fill");
    check("t6_cnt6", 32'(free_cnt), 6);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_cnt", 32'(free_cnt), 16);
    check("t6_async_num1", 32'(num_1), 0);
    check("t6_async_busy", 32'(dut.r_busy), 0);
    check("t6_async_afull", 32'(almost_full), 0);
    mb   = '0;
    merr = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) pair("t6_refill");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, "t6_to5");
    check("t6_afull_at5", 32'(almost_full), 0);
    check("t6_cnt5", 32'(free_cnt), 5);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, "t6_to4");
    check("t6_afull_at4", 32'(almost_full), 1);
    check("t6_cnt4", 32'(free_cnt), 4);
    idle("t6_after");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
